fb_ring_controller: RTL and testbench

FB_RING_CONTROLLER -- requirements
Module: fb_ring_controller

---
 rtl/fb_ring_controller.sv | 187 ++++++++++++++++++
 tb/tb_fb_ring_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_ring_controller.sv
// Purpose: N_BUF-deep ring of frame buffers with a background clear engine, swap arbitration and a display read port.
// Latency: display pixel one cycle after the read is issued; a swap takes effect on the clock edge it is accepted.
// Backpressure: ready drops while a clear or a deferred swap is outstanding; a second swap request while one is deferred is dropped and counted.
module fb_ring_controller #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int N_BUF     = 3,
    parameter int COLOR_W   = 4,
    parameter int SPLIT_ROW = 120,
    parameter int DROP_W    = 8,
    localparam int PIX      = WIDTH * HEIGHT,
    localparam int ADDR_W   = $clog2(PIX)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  w_addr,
    input  logic               w_en,
    input  logic [COLOR_W-1:0] w_color,
    input  logic               done,
    input  logic               r_en,
    input  logic [8:0]         row,
    input  logic [9:0]         col,
    output logic [COLOR_W-1:0] red_out,
    output logic [COLOR_W-1:0] green_out,
    output logic [COLOR_W-1:0] blue_out,
    output logic               ready,
    output logic [1:0]         rd_buf,
    output logic [DROP_W-1:0]  drop_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIX - 1);
    localparam logic [ADDR_W:0]   PIX_L     = (ADDR_W + 1)'(PIX);
    localparam logic [1:0]        BUF_LAST  = 2'(N_BUF - 1);
    localparam logic [8:0]        SPLIT_L   = 9'(SPLIT_ROW);

    // Control state
    logic              init;
    logic [ADDR_W-1:0] init_addr;
    logic [ADDR_W-1:0] clr_addr;
    logic              clear_done;
    logic              pending;
    logic              done_q;
    logic [1:0]        base;

    // Buffer roles derived from the base pointer
    logic [1:0]        wr_idx;
    logic [1:0]        clr_idx;
    logic              swap_req;
    logic              clear_last;
    logic              do_swap;
    logic              wr_ok;
    logic              rd_issue;
    logic [ADDR_W-1:0] rd_addr;

    // Read pipeline
    logic               rd_vld_q;
    logic [1:0]         rd_sel_q;
    logic [8:0]         rd_row_q;
    logic [COLOR_W-1:0] rd_word [4];
    logic [COLOR_W-1:0] pixel;

    // Role decode, swap decision and read/write qualification
    always_comb begin
        wr_idx     = (base == BUF_LAST) ? 2'd0 : base + 2'd1;
        clr_idx    = (base == 2'd0) ? BUF_LAST : base - 2'd1;
        swap_req   = done && !done_q && !init;
        clear_last = !clear_done && (clr_addr == ADDR_LAST);
        // A deferred swap fires on the clear's final write; the clear_done
        // term covers a request that became pending on that same edge.
        do_swap    = !init && ((swap_req && !pending && clear_done) ||
                               (pending && (clear_done || clear_last)));
        wr_ok      = w_en && ({1'b0, w_addr} < PIX_L) && !init;
        rd_issue   = r_en && (32'(row) < 32'(HEIGHT)) && (32'(col) < 32'(WIDTH)) && !init;
        rd_addr    = ADDR_W'(32'(row) * 32'(WIDTH) + 32'(col));
    end

    // Init sweep, clear engine, swap/pending arbitration and drop counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init       <= 1'b1;
            init_addr  <= '0;
            clr_addr   <= '0;
            clear_done <= 1'b0;
            pending    <= 1'b0;
            done_q     <= 1'b0;
            base       <= 2'd0;
            drop_cnt   <= '0;
        end else begin
            done_q <= done;
            if (init) begin
                if (init_addr == ADDR_LAST) begin
                    init       <= 1'b0;
                    clear_done <= 1'b1;
                end else begin
                    init_addr <= init_addr + 1'b1;
                end
            end else begin
                if (!clear_done) begin
                    if (clr_addr == ADDR_LAST) begin
                        clear_done <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                if (do_swap) begin
                    base       <= wr_idx;
                    clr_addr   <= '0;
                    clear_done <= 1'b0;
                    pending    <= 1'b0;
                end else if (swap_req && !pending && !clear_done) begin
                    pending <= 1'b1;
                end
                if (swap_req && pending && (drop_cnt != '1)) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    // One memory per buffer; the write port is shared by init, clear and writer,
    // which never target the same buffer outside the init sweep.
    for (genvar g = 0; g < 4; g++) begin : gen_buf
        if (g < N_BUF) begin : gen_mem
            localparam logic [1:0] BI = 2'(g);
            logic [COLOR_W-1:0] mem [PIX];
            logic [COLOR_W-1:0] rdata_q;
            logic               we;
            logic [ADDR_W-1:0]  wa;
            logic [COLOR_W-1:0] wd;

            // Select the write source for this buffer
            always_comb begin
                we = 1'b0;
                wa = clr_addr;
                wd = '0;
                if (init) begin
                    we = 1'b1;
                    wa = init_addr;
                end else if ((BI == clr_idx) && !clear_done) begin
                    we = 1'b1;
                    wa = clr_addr;
                end else if ((BI == wr_idx) && wr_ok) begin
                    we = 1'b1;
                    wa = w_addr;
                    wd = w_color;
                end
            end

            // Synchronous write and read
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[wa] <= wd;
                end
                rdata_q <= mem[rd_addr];
            end

            assign rd_word[g] = rdata_q;
        end else begin : gen_none
            assign rd_word[g] = '0;
        end
    end

    // Capture which buffer and row the read used so the output follows the pre-swap buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_q <= 1'b0;
            rd_sel_q <= 2'd0;
            rd_row_q <= '0;
        end else begin
            rd_vld_q <= rd_issue;
            rd_sel_q <= base;
            rd_row_q <= row;
        end
    end

    // Colour map: upper rows on red, lower rows on green, blue unused
    always_comb begin
        pixel     = rd_vld_q ? rd_word[rd_sel_q] : '0;
        red_out   = (rd_row_q <= SPLIT_L) ? pixel : '0;
        green_out = (rd_row_q <= SPLIT_L) ? '0 : pixel;
        blue_out  = '0;
    end

    assign ready  = clear_done && !pending && !init;
    assign rd_buf = base;

endmodule

// File: tb/tb_fb_ring_controller.sv
module tb_fb_ring_controller;

    localparam int WIDTH = 8;
    localparam int HEIGHT = 4;
    localparam int N_BUF = 3;
    localparam int COLOR_W = 4;
    localparam int SPLIT_ROW = 1;
    localparam int DROP_W = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [4:0]         w_addr = '0;
    logic               w_en = 1'b0;
    logic [COLOR_W-1:0] w_color = '0;
    logic               done = 1'b0;
    logic               r_en = 1'b0;
    logic [8:0]         row = '0;
    logic [9:0]         col = '0;
    logic [COLOR_W-1:0] red_out, green_out, blue_out;
    logic               ready;
    logic [1:0]         rd_buf;
    logic [DROP_W-1:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int swap_cyc = 0;

    fb_ring_controller #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .N_BUF(N_BUF), .COLOR_W(COLOR_W),
        .SPLIT_ROW(SPLIT_ROW), .DROP_W(DROP_W)
    ) dut (
        .clk(clk), .rst(rst), .w_addr(w_addr), .w_en(w_en), .w_color(w_color),
        .done(done), .r_en(r_en), .row(row), .col(col),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .ready(ready), .rd_buf(rd_buf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_read(input int r, input int c);
        r_en = 1'b1;
        row = 9'(r);
        col = 10'(c);
        tick();
        r_en = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [3:0] d);
        w_en = 1'b1;
        w_addr = 5'(a);
        w_color = d;
        tick();
        w_en = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int n;
        logic bad_out;
        rst = 1'b0;
        #3;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0h exp 0", ready); end
        checks++; if (rd_buf !== 2'd0) begin errors++; $display("FAIL rst_rd_buf got %0h exp 0", rd_buf); end
        checks++; if (drop_cnt !== 2'd0) begin errors++; $display("FAIL rst_drop got %0h exp 0", drop_cnt); end
        checks++; if ({red_out, green_out, blue_out} !== 12'h0) begin errors++; $display("FAIL rst_rgb got %0h exp 0", {red_out, green_out, blue_out}); end
        tick();
        tick();
        rst = 1'b1;
        // Writes, swap requests and reads during the sweep must all be ignored
        w_en = 1'b1; w_addr = 5'd3; w_color = 4'hF;
        done = 1'b1;
        r_en = 1'b1; row = 9'd0; col = 10'd3;
        n = 0;
        bad_out = 1'b0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (n == 2) done = 1'b0;
            if ({red_out, green_out} !== 8'h0) bad_out = 1'b1;
        end
        w_en = 1'b0; r_en = 1'b0;
        checks++; if (n != 32) begin errors++; $display("FAIL init_len got %0d exp 32", n); end
        checks++; if (bad_out !== 1'b0) begin errors++; $display("FAIL init_out got %0h exp 0", bad_out); end
        checks++; if (rd_buf !== 2'd0) begin errors++; $display("FAIL init_rd_buf got %0h exp 0", rd_buf); end
        do_read(0, 0);
        checks++; if (red_out !== 4'h0) begin errors++; $display("FAIL init_read got %0h exp 0", red_out); end
    endtask

    task automatic test_swap();
        do_write(9, 4'hA);
        do_write(26, 4'h5);
        done = 1'b1;
        tick();
        swap_cyc = cyc;
        done = 1'b0;
        checks++; if (rd_buf !== 2'd1) begin errors++; $display("FAIL swap_rd_buf got %0h exp 1", rd_buf); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL swap_ready got %0h exp 0", ready); end
        do_read(1, 1);
        checks++; if (red_out !== 4'hA) begin errors++; $display("FAIL swap_red got %0h exp a", red_out); end
        checks++; if ({green_out, blue_out} !== 8'h0) begin errors++; $display("FAIL swap_gb got %0h exp 0", {green_out, blue_out}); end
        do_read(3, 2);
        checks++; if (green_out !== 4'h5) begin errors++; $display("FAIL swap_green got %0h exp 5", green_out); end
        checks++; if (red_out !== 4'h0) begin errors++; $display("FAIL swap_green_red got %0h exp 0", red_out); end
        do_read(0, 3);
        checks++; if (red_out !== 4'h0) begin errors++; $display("FAIL init_write_ignored got %0h exp 0", red_out); end
    endtask

    task automatic test_pending();
        tick();
        pulse_done();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL pend_ready got %0h exp 0", ready); end
        checks++; if (dut.pending !== 1'b1) begin errors++; $display("FAIL pend_flag got %0h exp 1", dut.pending); end
        checks++; if (rd_buf !== 2'd1) begin errors++; $display("FAIL pend_rd_buf got %0h exp 1", rd_buf); end
        do_write(5, 4'h7);
        while (cyc < swap_cyc + 31) tick();
        checks++; if (rd_buf !== 2'd1) begin errors++; $display("FAIL pre_swap_rd_buf got %0h exp 1", rd_buf); end
        // Write and read issued on the swap edge itself
        w_en = 1'b1; w_addr = 5'd6; w_color = 4'h3;
        r_en = 1'b1; row = 9'd1; col = 10'd1;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        swap_cyc = cyc;
        checks++; if (rd_buf !== 2'd2) begin errors++; $display("FAIL pend_swap_rd_buf got %0h exp 2", rd_buf); end
        checks++; if (red_out !== 4'hA) begin errors++; $display("FAIL swap_cycle_read got %0h exp a", red_out); end
        checks++; if (dut.pending !== 1'b0) begin errors++; $display("FAIL pend_cleared got %0h exp 0", dut.pending); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL pend_swap_ready got %0h exp 0", ready); end
        do_read(0, 5);
        checks++; if (red_out !== 4'h7) begin errors++; $display("FAIL pend_write got %0h exp 7", red_out); end
        do_read(0, 6);
        checks++; if (red_out !== 4'h3) begin errors++; $display("FAIL swap_cycle_write got %0h exp 3", red_out); end
    endtask

    task automatic test_drop();
        int n;
        pulse_done();
        checks++; if (dut.pending !== 1'b1 || drop_cnt !== 2'd0) begin errors++; $display("FAIL drop_first got %0h/%0h exp 1/0", dut.pending, drop_cnt); end
        pulse_done();
        checks++; if (drop_cnt !== 2'd1) begin errors++; $display("FAIL drop_one got %0h exp 1", drop_cnt); end
        pulse_done();
        pulse_done();
        pulse_done();
        checks++; if (drop_cnt !== 2'd3) begin errors++; $display("FAIL drop_sat got %0h exp 3", drop_cnt); end
        checks++; if (rd_buf !== 2'd2) begin errors++; $display("FAIL drop_no_early got %0h exp 2", rd_buf); end
        n = 0;
        while (rd_buf === 2'd2 && n < 100) begin tick(); n++; end
        checks++; if (rd_buf !== 2'd0 || cyc != swap_cyc + 32) begin errors++; $display("FAIL drop_swap got buf %0h at %0d exp buf 0 at %0d", rd_buf, cyc - swap_cyc, 32); end
        n = 0;
        while (ready !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n != 32) begin errors++; $display("FAIL drop_clear_len got %0d exp 32", n); end
        checks++; if (rd_buf !== 2'd0 || drop_cnt !== 2'd3) begin errors++; $display("FAIL drop_single got %0h/%0h exp 0/3", rd_buf, drop_cnt); end
    endtask

    task automatic test_range();
        do_write(0, 4'hF);
        do_write(8, 4'hF);
        pulse_done();
        checks++; if (rd_buf !== 2'd1) begin errors++; $display("FAIL range_rd_buf got %0h exp 1", rd_buf); end
        do_read(0, 0);
        checks++; if (red_out !== 4'hF) begin errors++; $display("FAIL range_valid got %0h exp f", red_out); end
        do_read(4, 0);
        checks++; if ({red_out, green_out} !== 8'h0) begin errors++; $display("FAIL range_row got %0h exp 0", {red_out, green_out}); end
        do_read(0, 8);
        checks++; if ({red_out, green_out} !== 8'h0) begin errors++; $display("FAIL range_col got %0h exp 0", {red_out, green_out}); end
    endtask

    task automatic test_reset_pending();
        int n;
        pulse_done();
        checks++; if (dut.pending !== 1'b1) begin errors++; $display("FAIL rp_pending got %0h exp 1", dut.pending); end
        rst = 1'b0;
        #2;
        checks++; if (dut.pending !== 1'b0) begin errors++; $display("FAIL rp_pend_clr got %0h exp 0", dut.pending); end
        checks++; if (drop_cnt !== 2'd0) begin errors++; $display("FAIL rp_drop got %0h exp 0", drop_cnt); end
        checks++; if (rd_buf !== 2'd0) begin errors++; $display("FAIL rp_rd_buf got %0h exp 0", rd_buf); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rp_ready got %0h exp 0", ready); end
        tick();
        rst = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n != 32) begin errors++; $display("FAIL rp_init_len got %0d exp 32", n); end
        pulse_done();
        checks++; if (rd_buf !== 2'd1) begin errors++; $display("FAIL rp_swap got %0h exp 1", rd_buf); end
        do_read(0, 0);
        checks++; if (red_out !== 4'h0) begin errors++; $display("FAIL rp_mem_cleared got %0h exp 0", red_out); end
    endtask

    initial begin
        test_reset();
        test_swap();
        test_pending();
        test_drop();
        test_range();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
